// File: rtl/spi_device_pkg.sv
// -----------------------------------------------------------------------------
// spi_device_pkg
// Shared definitions for the SPI device transmit path: serializer state
// encoding, the default idle fill pattern, the byte-counter width and the
// bit-order helpers used when loading and shifting a byte.
// -----------------------------------------------------------------------------
package spi_device_pkg;

   // Serializer states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StShift = 2'd2
   } txs_st_e;

   // Pattern driven on the line when no data byte is buffered
   localparam logic [7:0] IdleByteDefault = 8'hFF;

   // Width of the per-transfer completed-byte counter
   localparam int unsigned ByteCntW = 16;

   // First bit presented on the line for a freshly loaded byte
   function automatic logic tx_first_bit(input logic [7:0] b, input logic lsb_first);
      logic bit_s;
      if (lsb_first) begin
         bit_s = b[0];
      end else begin
         bit_s = b[7];
      end
      return bit_s;
   endfunction

   // Shift register contents after one bit has left the line
   function automatic logic [7:0] tx_shift_byte(input logic [7:0] b, input logic lsb_first);
      logic [7:0] res_s;
      if (lsb_first) begin
         res_s = {1'b0, b[7:1]};
      end else begin
         res_s = {b[6:0], 1'b0};
      end
      return res_s;
   endfunction

endpackage : spi_device_pkg

// File: rtl/spi_txf_buf.sv
// -----------------------------------------------------------------------------
// spi_txf_buf
// Small synchronous pointer FIFO between the upstream TX FIFO controller and
// the serializer. Pointers carry one extra wrap bit so full and empty can be
// told apart without a separate counter. There is no bypass: a byte written
// in one cycle is visible at the head no earlier than the next cycle.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   wvalid_i       write request
//   wready_o       buffer not full (from registered pointers only)
//   wdata_i        write data
//   pop_i          remove head entry (ignored when empty)
//   rdata_o        head entry
//   empty_o        buffer empty
//   level_o        occupancy, wptr - rptr modulo 2^(AW+1)
// -----------------------------------------------------------------------------
module spi_txf_buf
   import spi_device_pkg::*;
#(
   parameter int unsigned Dw    = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wvalid_i,
   output logic                     wready_o,
   input  logic [Dw-1:0]            wdata_i,
   input  logic                     pop_i,
   output logic [Dw-1:0]            rdata_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   level_o
);

   localparam int unsigned AW = $clog2(Depth);

   if ((Depth < 32'd2) || ((Depth & (Depth - 32'd1)) != 32'd0)) begin : g_bad_depth
      $error("spi_txf_buf: Depth must be a power of two and at least 2");
   end

   logic [AW:0]   wptr_r;
   logic [AW:0]   rptr_r;
   logic [Dw-1:0] mem_r [Depth];
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;

   // Flags and handshake qualifiers from the registered pointers
   always_comb begin
      full_s  = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
      empty_s = (wptr_r == rptr_r);
      push_s  = wvalid_i && !full_s;
      pop_s   = pop_i && !empty_s;
   end

   assign wready_o = !full_s;
   assign empty_o  = empty_s;
   assign level_o  = wptr_r - rptr_r;
   assign rdata_o  = mem_r[rptr_r[AW-1:0]];

   // Pointer update for accepted pushes and pops
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_r <= {(AW+1){1'b0}};
         rptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array, written at the write index on an accepted push
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_r[i] <= {Dw{1'b0}};
         end
      end else if (push_s) begin
         mem_r[wptr_r[AW-1:0]] <= wdata_i;
      end
   end

endmodule : spi_txf_buf

// File: rtl/spi_txf_serializer.sv
// -----------------------------------------------------------------------------
// spi_txf_serializer
// Byte-to-bit transmit stage. Bytes arrive over valid/ready into a small
// buffer and are shifted out one bit per shift_i strobe while chip-select is
// active. An idle byte is substituted when the buffer is empty, and a
// transfer that ends with a byte partly shifted raises abort_o.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   fifo_valid_i   upstream byte valid
//   fifo_ready_o   buffer not full
//   fifo_wdata_i   upstream byte
//   cs_active_i    chip-select active (already synchronized)
//   shift_i        one-cycle strobe, advances one bit
//   lsb_first_i    bit order, sampled whenever a byte is loaded
//   sdo_o          serial data out (registered)
//   sdo_oe_o       serial output enable (registered)
//   abort_o        pulse: transfer ended mid-byte
//   underflow_o    pulse: idle byte loaded
//   byte_cnt_o     data bytes completed in the current transfer (saturating)
//   level_o        buffer occupancy
// -----------------------------------------------------------------------------
module spi_txf_serializer
   import spi_device_pkg::*;
#(
   parameter int unsigned FifoDw   = 8,
   parameter int unsigned Depth    = 4,
   parameter logic [7:0]  IdleByte = IdleByteDefault
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     fifo_valid_i,
   output logic                     fifo_ready_o,
   input  logic [FifoDw-1:0]        fifo_wdata_i,
   input  logic                     cs_active_i,
   input  logic                     shift_i,
   input  logic                     lsb_first_i,
   output logic                     sdo_o,
   output logic                     sdo_oe_o,
   output logic                     abort_o,
   output logic                     underflow_o,
   output logic [ByteCntW-1:0]      byte_cnt_o,
   output logic [$clog2(Depth):0]   level_o
);

   if (FifoDw != 32'd8) begin : g_bad_dw
      $error("spi_txf_serializer: FifoDw must be 8");
   end

   localparam logic [ByteCntW-1:0] ByteCntMax = {ByteCntW{1'b1}};
   localparam logic [ByteCntW-1:0] ByteCntOne = {{(ByteCntW-1){1'b0}}, 1'b1};

   txs_st_e           st_r;
   logic [FifoDw-1:0] shreg_r;
   logic [2:0]        bit_cnt_r;
   logic              lsb_r;
   logic              is_data_r;

   logic [FifoDw-1:0] head_s;
   logic [FifoDw-1:0] load_byte_s;
   logic [FifoDw-1:0] shifted_s;
   logic              buf_empty_s;
   logic              last_bit_s;
   logic              reload_s;
   logic              pop_s;

   spi_txf_buf #(
      .Dw    (FifoDw),
      .Depth (Depth)
   ) u_buf (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .wvalid_i (fifo_valid_i),
      .wready_o (fifo_ready_o),
      .wdata_i  (fifo_wdata_i),
      .pop_i    (pop_s),
      .rdata_o  (head_s),
      .empty_o  (buf_empty_s),
      .level_o  (level_o)
   );

   // Decide when a byte is loaded and what gets loaded; a deasserting
   // chip-select suppresses any load, including one coinciding with a strobe
   always_comb begin
      last_bit_s  = (bit_cnt_r == 3'd7);
      shifted_s   = tx_shift_byte(shreg_r, lsb_r);
      load_byte_s = IdleByte;
      reload_s    = 1'b0;
      if (buf_empty_s) begin
         load_byte_s = IdleByte;
      end else begin
         load_byte_s = head_s;
      end
      case (st_r)
         StIdle:  reload_s = 1'b0;
         StLoad:  reload_s = cs_active_i;
         StShift: reload_s = cs_active_i && shift_i && last_bit_s;
         default: reload_s = 1'b0;
      endcase
      pop_s = reload_s && !buf_empty_s;
   end

   // Serializer FSM with registered line outputs and status pulses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_r        <= StIdle;
         shreg_r     <= {FifoDw{1'b0}};
         bit_cnt_r   <= 3'd0;
         lsb_r       <= 1'b0;
         is_data_r   <= 1'b0;
         sdo_o       <= 1'b0;
         sdo_oe_o    <= 1'b0;
         abort_o     <= 1'b0;
         underflow_o <= 1'b0;
         byte_cnt_o  <= {ByteCntW{1'b0}};
      end else begin
         abort_o     <= 1'b0;
         underflow_o <= 1'b0;
         if (!cs_active_i) begin
            // A partial byte is dropped; buffered bytes stay for the next transfer
            abort_o   <= (st_r == StShift) && (bit_cnt_r != 3'd0);
            st_r      <= StIdle;
            bit_cnt_r <= 3'd0;
            sdo_o     <= 1'b0;
            sdo_oe_o  <= 1'b0;
         end else begin
            case (st_r)
               StIdle: begin
                  st_r       <= StLoad;
                  byte_cnt_o <= {ByteCntW{1'b0}};
               end
               StLoad: begin
                  st_r        <= StShift;
                  shreg_r     <= load_byte_s;
                  lsb_r       <= lsb_first_i;
                  is_data_r   <= !buf_empty_s;
                  underflow_o <= buf_empty_s;
                  bit_cnt_r   <= 3'd0;
                  sdo_o       <= tx_first_bit(load_byte_s, lsb_first_i);
                  sdo_oe_o    <= 1'b1;
               end
               StShift: begin
                  sdo_oe_o <= 1'b1;
                  if (shift_i) begin
                     if (last_bit_s) begin
                        // Byte boundary: reload in the same cycle so no gap appears
                        shreg_r     <= load_byte_s;
                        lsb_r       <= lsb_first_i;
                        is_data_r   <= !buf_empty_s;
                        underflow_o <= buf_empty_s;
                        bit_cnt_r   <= 3'd0;
                        sdo_o       <= tx_first_bit(load_byte_s, lsb_first_i);
                        if (is_data_r && (byte_cnt_o != ByteCntMax)) begin
                           byte_cnt_o <= byte_cnt_o + ByteCntOne;
                        end
                     end else begin
                        shreg_r   <= shifted_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        sdo_o     <= tx_first_bit(shifted_s, lsb_r);
                     end
                  end
               end
               default: begin
                  st_r     <= StIdle;
                  sdo_o    <= 1'b0;
                  sdo_oe_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : spi_txf_serializer

// File: tb/tb_spi_txf_serializer.sv
// -----------------------------------------------------------------------------
// tb_spi_txf_serializer
// Directed bench: a table of single-byte transfers with hand-computed serial
// streams, followed by hand-written sequences for underflow, buffer full,
// abort with a coinciding strobe, and asynchronous reset mid-byte.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_txf_serializer;

   localparam int unsigned Depth = 4;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         fifo_valid_i = 1'b0;
   logic         fifo_ready_o;
   logic [7:0]   fifo_wdata_i = 8'h00;
   logic         cs_active_i = 1'b0;
   logic         shift_i = 1'b0;
   logic         lsb_first_i = 1'b0;
   logic         sdo_o;
   logic         sdo_oe_o;
   logic         abort_o;
   logic         underflow_o;
   logic [15:0]  byte_cnt_o;
   logic [2:0]   level_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [7:0] data;
      logic       lsb;
      logic [7:0] stream;   // bit 7 is the first bit expected on sdo_o
   } vec_t;

   vec_t vecs [4];

   spi_txf_serializer #(
      .FifoDw   (8),
      .Depth    (Depth),
      .IdleByte (8'hFF)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .fifo_valid_i (fifo_valid_i),
      .fifo_ready_o (fifo_ready_o),
      .fifo_wdata_i (fifo_wdata_i),
      .cs_active_i  (cs_active_i),
      .shift_i      (shift_i),
      .lsb_first_i  (lsb_first_i),
      .sdo_o        (sdo_o),
      .sdo_oe_o     (sdo_oe_o),
      .abort_o      (abort_o),
      .underflow_o  (underflow_o),
      .byte_cnt_o   (byte_cnt_o),
      .level_o      (level_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ready"},     32'(fifo_ready_o), 32'd1);
      chk({tag, " sdo"},       32'(sdo_o),        32'd0);
      chk({tag, " oe"},        32'(sdo_oe_o),     32'd0);
      chk({tag, " abort"},     32'(abort_o),      32'd0);
      chk({tag, " underflow"}, 32'(underflow_o),  32'd0);
      chk({tag, " byte_cnt"},  32'(byte_cnt_o),   32'd0);
      chk({tag, " level"},     32'(level_o),      32'd0);
   endtask

   task automatic push(input logic [7:0] b);
      fifo_valid_i = 1'b1;
      fifo_wdata_i = b;
      tick();
      fifo_valid_i = 1'b0;
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] d [5];
      logic [7:0] aa_stream;

      vecs[0] = '{data: 8'hA5, lsb: 1'b0, stream: 8'hA5};
      vecs[1] = '{data: 8'h01, lsb: 1'b1, stream: 8'h80};
      vecs[2] = '{data: 8'hC1, lsb: 1'b1, stream: 8'h83};
      vecs[3] = '{data: 8'h4E, lsb: 1'b0, stream: 8'h4E};

      // Reset state
      tick();
      tick();
      chk_reset_vals("rst");
      rst_ni = 1'b1;
      tick();

      // Table-driven single-byte transfers
      for (int i = 0; i < 4; i++) begin
         lsb_first_i = vecs[i].lsb;
         push(vecs[i].data);
         chk($sformatf("v%0d level", i), 32'(level_o), 32'd1);
         cs_active_i = 1'b1;
         tick();
         chk($sformatf("v%0d oe_load", i), 32'(sdo_oe_o), 32'd0);
         tick();
         chk($sformatf("v%0d oe", i), 32'(sdo_oe_o), 32'd1);
         chk($sformatf("v%0d uf_load", i), 32'(underflow_o), 32'd0);
         chk($sformatf("v%0d cnt0", i), 32'(byte_cnt_o), 32'd0);
         for (int b = 0; b < 8; b++) begin
            chk($sformatf("v%0d bit%0d", i, b), 32'(sdo_o), 32'(vecs[i].stream[7-b]));
            shift_i = 1'b1;
            tick();
         end
         shift_i = 1'b0;
         chk($sformatf("v%0d cnt1", i), 32'(byte_cnt_o), 32'd1);
         chk($sformatf("v%0d uf_reload", i), 32'(underflow_o), 32'd1);
         chk($sformatf("v%0d idle_bit", i), 32'(sdo_o), 32'd1);
         cs_active_i = 1'b0;
         tick();
         chk($sformatf("v%0d oe_off", i), 32'(sdo_oe_o), 32'd0);
         chk($sformatf("v%0d no_abort", i), 32'(abort_o), 32'd0);
         chk($sformatf("v%0d uf_pulse", i), 32'(underflow_o), 32'd0);
      end

      // Empty buffer: idle bytes only, no data counted
      lsb_first_i = 1'b0;
      cs_active_i = 1'b1;
      tick();
      tick();
      chk("uf first", 32'(underflow_o), 32'd1);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("uf bit%0d", b), 32'(sdo_o), 32'd1);
         if (b > 0) chk($sformatf("uf quiet%0d", b), 32'(underflow_o), 32'd0);
         shift_i = 1'b1;
         tick();
      end
      shift_i = 1'b0;
      chk("uf cnt", 32'(byte_cnt_o), 32'd0);
      chk("uf reload", 32'(underflow_o), 32'd1);
      cs_active_i = 1'b0;
      tick();
      chk("uf no_abort", 32'(abort_o), 32'd0);

      // Fill to full with cs low, then drain while the fifth byte waits
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fill ready%0d", k), 32'(fifo_ready_o), 32'd1);
         fifo_valid_i = 1'b1;
         fifo_wdata_i = d[k];
         tick();
      end
      fifo_wdata_i = d[4];
      chk("full ready", 32'(fifo_ready_o), 32'd0);
      chk("full level", 32'(level_o), 32'd4);
      tick();
      chk("full hold level", 32'(level_o), 32'd4);
      cs_active_i = 1'b1;
      tick();
      tick();
      chk("drain ready", 32'(fifo_ready_o), 32'd1);
      chk("drain level", 32'(level_o), 32'd3);
      rx = 8'h00;
      for (int j = 0; j < 40; j++) begin
         rx = {rx[6:0], sdo_o};
         if ((j % 8) == 7) chk($sformatf("drain byte%0d", j / 8), 32'(rx), 32'(d[j / 8]));
         shift_i = 1'b1;
         tick();
         if (j == 0) begin
            chk("fifth accepted", 32'(level_o), 32'd4);
            fifo_valid_i = 1'b0;
         end
      end
      shift_i = 1'b0;
      chk("drain cnt", 32'(byte_cnt_o), 32'd5);
      chk("drain empty", 32'(level_o), 32'd0);
      chk("drain uf", 32'(underflow_o), 32'd1);
      cs_active_i = 1'b0;
      tick();

      // Abort after 3 strobes; cs drop coincides with a 4th strobe
      lsb_first_i = 1'b0;
      push(8'hAA);
      push(8'hBB);
      cs_active_i = 1'b1;
      tick();
      tick();
      aa_stream = 8'hAA;
      for (int b = 0; b < 3; b++) begin
         chk($sformatf("ab bit%0d", b), 32'(sdo_o), 32'(aa_stream[7-b]));
         shift_i = 1'b1;
         tick();
      end
      cs_active_i = 1'b0;
      shift_i = 1'b1;
      tick();
      shift_i = 1'b0;
      chk("ab pulse", 32'(abort_o), 32'd1);
      chk("ab oe", 32'(sdo_oe_o), 32'd0);
      chk("ab level", 32'(level_o), 32'd1);
      chk("ab cnt", 32'(byte_cnt_o), 32'd0);
      chk("ab no_uf", 32'(underflow_o), 32'd0);
      tick();
      chk("ab one_cycle", 32'(abort_o), 32'd0);
      cs_active_i = 1'b1;
      tick();
      tick();
      chk("ab next uf", 32'(underflow_o), 32'd0);
      rx = 8'h00;
      for (int b = 0; b < 8; b++) begin
         rx = {rx[6:0], sdo_o};
         shift_i = 1'b1;
         tick();
      end
      shift_i = 1'b0;
      chk("ab next byte", 32'(rx), 32'hBB);
      chk("ab next cnt", 32'(byte_cnt_o), 32'd1);
      cs_active_i = 1'b0;
      tick();

      // Asynchronous reset mid-byte with three bytes still buffered
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      cs_active_i = 1'b1;
      tick();
      tick();
      shift_i = 1'b1;
      tick();
      tick();
      shift_i = 1'b0;
      chk("mid level", 32'(level_o), 32'd3);
      chk("mid oe", 32'(sdo_oe_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk_reset_vals("async");
      tick();
      cs_active_i = 1'b0;
      rst_ni = 1'b1;
      tick();
      chk("post rst oe", 32'(sdo_oe_o), 32'd0);
      chk("post rst level", 32'(level_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_spi_txf_serializer
